mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the 512 x 32 single-port synchronous RAM. It shares the RAM between the CPU instruction-fetch port (read-only) and the data load/store port (read/write). It grants at most one access per cycle with round-robin fairness, drives the RAM control strobes and tracks the one-cycle read latency. It returns read data to the correct requester and keeps saturating stall counters for performance debug.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, RAM data width
- CNT_W, 16, stall counter width
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- arb_enable  in  1  1 = new grants allowed; 0 = no new grants, in-flight read still completes
- if_req  in  1  fetch request; held with if_addr until accepted
- if_addr  in  ADDR_W  fetch word address
- if_ready  out  1  grant; access accepted in any cycle with if_req & if_ready
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until accepted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  grant
- d_rvalid  out  1  one-cycle pulse on read completion
- d_wack  out  1  one-cycle pulse the cycle after a write is accepted
- d_rdata  out  DATA_W  data read data
- ram_read  out  1  to RAM memRead
- ram_write  out  1  to RAM memWrite
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM dataIn
- ram_rdata  in  DATA_W  from RAM dataOut; valid the cycle after ram_read
- if_stall_cnt  out  CNT_W  cycles with if_req high and if_ready low, saturating
- d_stall_cnt  out  CNT_W  same for the data port

## Operation
- Grant is combinational from the current requests, arb_enable and the last_grant register. At most one of if_ready and d_ready is high per cycle.
- Only one requester active: it is granted.
- Both requesting: the port not granted last wins.
- last_grant updates only on an accepted access.
- Accepted access drives the RAM in the same cycle.
  - ram_addr is the winner's address.
  - ram_read = !we.
  - ram_write = we; a fetch is always a read.
- With no grant, ram_read = ram_write = 0. ram_addr and ram_wdata hold their last values and are don't-care.
- The response register records rsp_valid, rsp_port (IF/D) and rsp_is_write for the accepted access.
  - Next cycle, a read pulses the owning port's rvalid, with rdata = ram_rdata passed through.
  - A write pulses d_wack.
- A new access may be accepted in the same cycle a response is returned: full one-access-per-cycle throughput, no bubbles.
- The RAM read port holds dataOut when ram_read = 0. The rdata outputs are only meaningful with rvalid.
- Stall counters increment when req & !ready and saturate at all-ones. They never wrap.

## Timing
- Reset (reset_n low at a rising edge) clears:
  - last_grant = D, so the first contested grant goes to IF.
  - rsp_valid = 0.
  - Stall counters = 0.
- All outputs during and after reset:
  - if_ready, d_ready, ram_read, ram_write follow requests with the cleared state, but are forced 0 while reset_n = 0.
  - if_rvalid, d_rvalid, d_wack = 0.
  - rdata outputs and ram_addr = 0.
- Read latency: accepted in cycle N, rvalid in cycle N+1.
- Write: the RAM array is updated at the edge ending cycle N; d_wack in N+1.
- Read-after-write to the same address in consecutive grants returns the new data.
- Reset mid-operation:
  - An in-flight read response is dropped; no rvalid after reset.
  - A write accepted before the reset edge is committed.
- arb_enable = 0: both ready = 0. A pending response is still delivered. Stall counters keep counting.
- A request dropped before acceptance is legal and ignored.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Port-ID encoding PORT_IF = 0, PORT_D = 1.
  - The response record (valid, port, is_write).
- One sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register. It is reusable for the upcoming I/O port sharing.
- Stall counters use a local saturating counter; no separate module.

## Test plan
- Single fetch: if_req with if_addr = 0x005, RAM preloaded with 0x00000065 at address 5.
  - if_ready in N.
  - if_rvalid in N+1 with if_rdata = 0x00000065.
- Contention: if_req and d_req (read 0x010) held high for 4 cycles after reset.
  - Grants are IF, D, IF, D.
  - rvalid pulses alternate ports one cycle later, with no idle cycle.
- Write then read: d write 0x1FF = 0xDEADBEEF accepted in N, d read 0x1FF in N+1.
  - d_wack in N+1.
  - d_rvalid in N+2 with 0xDEADBEEF.
- Back-pressure: arb_enable = 0 for 10 cycles with both requests high.
  - No grants.
  - if_stall_cnt = d_stall_cnt = 10.
  - With CNT_W = 4 forced, counters saturate at 15.
- Reset mid-read: read accepted in N, reset_n low in N+1.
  - No rvalid.
  - All outputs 0.
  - First grant after reset to IF when both request.
- Boundary address: read at 0x000 and 0x1FF back-to-back from the D port returns the correct words, with no address wrap artefacts.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RAM sharing logic (mem_arbiter, rr_arb2).
//   MEM_ADDR_W / MEM_DATA_W / MEM_CNT_W : default widths for the 512 x 32 RAM
//                                         and the stall counters
//   port_e                              : requester identity (PORT_IF, PORT_D)
//   rsp_t                               : response record for the access
//                                         accepted in the previous cycle
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_CNT_W  = 16;

    // The port ID doubles as the bit index into the two-bit request/grant
    // vectors used by rr_arb2.
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_write;
    } rsp_t;

    localparam rsp_t RSP_IDLE = '{valid: 1'b0, port: PORT_IF, is_write: 1'b0};

    // The port that wins a contested cycle is the one that did not win last.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_IF) ? PORT_D : PORT_IF;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant with a last_grant register.
//   clock    in   single clock, rising edge
//   reset_n  in   synchronous active-low reset; last_grant -> PORT_D, so the
//                 first contested grant after reset goes to PORT_IF
//   enable   in   1 = grants allowed, 0 = no grants
//   req      in   [1:0] request per port, indexed by port_e
//   grant    out  [1:0] one-hot or zero; combinational from req, enable and
//                 last_grant; forced to zero while reset_n is low
//
// A grant is always an accepted transfer: grant[i] is only raised when req[i]
// is high, so last_grant simply follows whichever grant bit is set.
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    port_e last_grant;
    port_e winner;

    // Only consulted when both ports request.
    assign winner = other_port(last_grant);

    always_comb begin
        grant = 2'b00;
        if (reset_n && enable) begin
            if (req == 2'b11) begin
                grant = (winner == PORT_IF) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant <= PORT_D;
        end else if (grant[PORT_IF]) begin
            last_grant <= PORT_IF;
        end else if (grant[PORT_D]) begin
            last_grant <= PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the 512 x 32 single-port synchronous RAM between the instruction
// fetch port (read-only) and the data load/store port. At most one access is
// accepted per cycle; the accepted access drives the RAM in that same cycle
// and its response (read data or write acknowledge) appears the next cycle.
//
// Handshake: a port holds req (and its address/data) until it sees req & ready
// high in the same cycle; that cycle is the acceptance. ready never depends on
// anything but the current requests, arb_enable, reset_n and the arbitration
// history. Responses are one-cycle pulses with no back-pressure.
//
// Ports
//   clock, reset_n          single clock, synchronous active-low reset
//   arb_enable              0 blocks new grants; a pending response completes
//   if_req/if_addr          fetch request (read-only)
//   if_ready                fetch grant
//   if_rvalid/if_rdata      fetch read response, cycle after acceptance
//   d_req/d_we/d_addr/
//   d_wdata                 data request
//   d_ready                 data grant
//   d_rvalid/d_rdata        data read response, cycle after acceptance
//   d_wack                  write acknowledge, cycle after acceptance
//   ram_read/ram_write/
//   ram_addr/ram_wdata      RAM control, driven in the acceptance cycle
//   ram_rdata               RAM dataOut, valid the cycle after ram_read
//   if_stall_cnt/
//   d_stall_cnt             saturating count of cycles with req & !ready
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = MEM_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              arb_enable,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic              d_wack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic [CNT_W-1:0]  if_stall_cnt,
    output logic [CNT_W-1:0]  d_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] grant;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (arb_enable),
        .req     ({d_req, if_req}),
        .grant   (grant)
    );

    logic accept;
    logic accept_we;

    assign if_ready  = grant[PORT_IF];
    assign d_ready   = grant[PORT_D];
    assign accept    = if_ready | d_ready;
    // A fetch can never write, so only the data port's d_we matters.
    assign accept_we = d_ready & d_we;

    // -------------------------------------------------------------------------
    // RAM control
    // Address and write data hold their last driven values between accesses;
    // the RAM ignores them then, holding avoids needless toggling.
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign ram_read  = accept & ~accept_we;
    assign ram_write = accept_we;

    always_comb begin
        ram_addr = addr_q;
        if (!reset_n) begin
            ram_addr = '0;
        end else if (d_ready) begin
            ram_addr = d_addr;
        end else if (if_ready) begin
            ram_addr = if_addr;
        end
    end

    always_comb begin
        ram_wdata = wdata_q;
        if (!reset_n) begin
            ram_wdata = '0;
        end else if (d_ready) begin
            ram_wdata = d_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Response tracking and state registers
    // -------------------------------------------------------------------------
    rsp_t rsp;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp          <= RSP_IDLE;
            if_stall_cnt <= '0;
            d_stall_cnt  <= '0;
        end else begin
            if (accept) begin
                addr_q <= ram_addr;
            end
            if (d_ready) begin
                wdata_q <= d_wdata;
            end

            // Rewritten every cycle so a response lives for exactly one cycle;
            // back-to-back accepts therefore give back-to-back responses.
            rsp.valid    <= accept;
            rsp.port     <= d_ready ? PORT_D : PORT_IF;
            rsp.is_write <= accept_we;

            if (if_req && !if_ready && (if_stall_cnt != CNT_MAX)) begin
                if_stall_cnt <= if_stall_cnt + 1'b1;
            end
            if (d_req && !d_ready && (d_stall_cnt != CNT_MAX)) begin
                d_stall_cnt <= d_stall_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response outputs
    // Gated by reset_n so a response in flight when reset asserts is dropped
    // in the very cycle reset is seen, not one edge later.
    // -------------------------------------------------------------------------
    logic rsp_read;

    assign rsp_read  = reset_n & rsp.valid & ~rsp.is_write;
    assign if_rvalid = rsp_read & (rsp.port == PORT_IF);
    assign d_rvalid  = rsp_read & (rsp.port == PORT_D);
    assign d_wack    = reset_n & rsp.valid & rsp.is_write;

    // Read data is the RAM output passed straight through, zeroed whenever it
    // is not valid for that port.
    assign if_rdata = if_rvalid ? ram_rdata : '0;
    assign d_rdata  = d_rvalid  ? ram_rdata : '0;

endmodule
